acc_array: RTL and testbench

ACC_ARRAY -- requirements
Module: acc_array

---
 rtl/acc_array.sv | 118 +++++++++++
 tb/tb_acc_array.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_array.sv
// acc_array: NUM_CH independent unsigned accumulator lanes run by an IDLE/RUN/DONE job FSM.
// Optional build macro ACC_ARRAY_SAT_EN clamps overflowing lanes instead of wrapping.
module acc_array #(
  parameter int NUM_CH        = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run_i,
  input  logic [CNT_WIDTH-1:0]            len_i,
  input  logic                            valid_i,
  input  logic [NUM_CH*IN_DATA_WIDTH-1:0] number_i,
  output logic                            idle_o,
  output logic                            running_o,
  output logic                            done_o,
  output logic [NUM_CH*DWIDTH-1:0]        result_o,
  output logic [NUM_CH-1:0]               ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       len_q, len_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [NUM_CH*DWIDTH-1:0]   acc_q, acc_d;
  logic [NUM_CH-1:0]          ovf_q, ovf_d;
  logic                       idle_q, running_q, done_q;
  logic [DWIDTH:0]            sum_s [NUM_CH];

  // Per-lane sum one bit wider than the accumulator; the top bit is the carry out.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s[k] = {1'b0, acc_q[k*DWIDTH +: DWIDTH]}
               + {{(DWIDTH+1-IN_DATA_WIDTH){1'b0}}, number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          acc_d   = '0;
          ovf_d   = '0;
          cnt_d   = '0;
          len_d   = len_i;
          state_d = (len_i == '0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (valid_i) begin
          for (int k = 0; k < NUM_CH; k++) begin
            // A lane that has ever carried stays flagged (and clamped when saturating).
            ovf_d[k] = ovf_q[k] | sum_s[k][DWIDTH];
`ifdef ACC_ARRAY_SAT_EN
            acc_d[k*DWIDTH +: DWIDTH] = ovf_d[k] ? {DWIDTH{1'b1}} : sum_s[k][DWIDTH-1:0];
`else
            acc_d[k*DWIDTH +: DWIDTH] = sum_s[k][DWIDTH-1:0];
`endif
          end
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == len_q - CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and status-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= '0;
      idle_q    <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      idle_q    <= (state_d == S_IDLE);
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign idle_o    = idle_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign result_o  = acc_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_acc_array.sv
// Self-checking bench for acc_array: randomized jobs checked against a plain-arithmetic lane-sum model.
module tb_acc_array;
  localparam int NCH = 4;
  localparam int IW  = 8;
  localparam int DW  = 16;
  localparam int CW  = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              run_i;
  logic [CW-1:0]     len_i;
  logic              valid_i;
  logic [NCH*IW-1:0] number_i;
  logic              idle_o, running_o, done_o;
  logic [NCH*DW-1:0] result_o;
  logic [NCH-1:0]    ovf_o;

  int n_tests = 0;
  int n_fail  = 0;
  longint sum_m [NCH];

  acc_array #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .len_i(len_i), .valid_i(valid_i),
    .number_i(number_i), .idle_o(idle_o), .running_o(running_o), .done_o(done_o),
    .result_o(result_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected lane value from the true (unbounded) sum.
  function automatic logic [DW-1:0] model_lane(input longint s);
`ifdef ACC_ARRAY_SAT_EN
    if (s > 65535) return 16'hFFFF;
    else return 16'(s);
`else
    return 16'(s % 65536);
`endif
  endfunction

  function automatic logic [NCH*DW-1:0] model_res();
    logic [NCH*DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = model_lane(sum_m[k]);
    return r;
  endfunction

  function automatic logic [NCH-1:0] model_ovf();
    logic [NCH-1:0] o;
    for (int k = 0; k < NCH; k++) o[k] = (sum_m[k] > 65535);
    return o;
  endfunction

  // Full job: start, beats with random gaps, completion, post-DONE hold.
  task automatic run_job(input int len, input int mode, input int gap_lo, input int gap_hi);
    int op;
    logic [NCH*DW-1:0] exp_r;
    for (int k = 0; k < NCH; k++) sum_m[k] = 0;
    run_i = 1'b1; len_i = CW'(len); valid_i = 1'($urandom_range(0, 1)); number_i = $urandom;
    tick();
    run_i = 1'b0;
    if (len == 0) begin
      n_tests++;
      if (done_o !== 1'b1 || idle_o !== 1'b0 || result_o !== '0 || ovf_o !== '0) begin
        n_fail++;
        $display("FAIL len0_done: done=%0b idle=%0b res=%h ovf=%b, want done=1 idle=0 res=0 ovf=0", done_o, idle_o, result_o, ovf_o);
      end
      valid_i = 1'b0;
      tick();
      n_tests++;
      if (idle_o !== 1'b1 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL len0_idle: idle=%0b done=%0b, want idle=1 done=0", idle_o, done_o);
      end
      return;
    end
    n_tests++;
    if (running_o !== 1'b1 || done_o !== 1'b0 || result_o !== '0 || ovf_o !== '0) begin
      n_fail++;
      $display("FAIL start: run=%0b done=%0b res=%h ovf=%b, want run=1 done=0 res=0 ovf=0", running_o, done_o, result_o, ovf_o);
    end
    for (int b = 0; b < len; b++) begin
      int gap;
      gap = (b == 0) ? 0 : $urandom_range(gap_lo, gap_hi);
      for (int g = 0; g < gap; g++) begin
        valid_i = 1'b0; run_i = 1'($urandom_range(0, 1)); number_i = $urandom;
        tick();
        n_tests++;
        if (running_o !== 1'b1 || done_o !== 1'b0 || result_o !== model_res()) begin
          n_fail++;
          $display("FAIL stall: run=%0b done=%0b res=%h, want run=1 done=0 res=%h", running_o, done_o, result_o, model_res());
        end
      end
      valid_i = 1'b1; run_i = 1'($urandom_range(0, 1));
      for (int k = 0; k < NCH; k++) begin
        case (mode)
          0:       op = $urandom_range(0, 255);
          1:       op = (k == 0) ? 255 : $urandom_range(0, 3);
          2:       op = k + 1;
          3:       op = 7;
          default: op = $urandom_range(200, 255);
        endcase
        number_i[k*IW +: IW] = IW'(op);
        sum_m[k] += op;
      end
      tick();
      exp_r = model_res();
      n_tests++;
      if (result_o !== exp_r || ovf_o !== model_ovf()) begin
        n_fail++;
        $display("FAIL beat%0d: res=%h ovf=%b, want res=%h ovf=%b", b, result_o, ovf_o, exp_r, model_ovf());
      end
      n_tests++;
      if (b == len - 1) begin
        if (done_o !== 1'b1 || running_o !== 1'b0) begin
          n_fail++;
          $display("FAIL done_pulse: done=%0b run=%0b, want done=1 run=0", done_o, running_o);
        end
      end else begin
        if (done_o !== 1'b0 || running_o !== 1'b1) begin
          n_fail++;
          $display("FAIL early_done: beat %0d done=%0b run=%0b, want done=0 run=1", b, done_o, running_o);
        end
      end
    end
    run_i = 1'b0; valid_i = 1'($urandom_range(0, 1)); number_i = $urandom;
    tick();
    n_tests++;
    if (idle_o !== 1'b1 || done_o !== 1'b0 || result_o !== model_res() || ovf_o !== model_ovf()) begin
      n_fail++;
      $display("FAIL hold: idle=%0b done=%0b res=%h ovf=%b, want idle=1 done=0 res=%h ovf=%b",
               idle_o, done_o, result_o, ovf_o, model_res(), model_ovf());
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run_i = 1'b1; valid_i = 1'b1; len_i = 9'd3; number_i = 32'hFFFF_FFFF;
    tick();
    tick();
    n_tests++;
    if (idle_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || ovf_o !== '0) begin
      n_fail++;
      $display("FAIL reset: idle=%0b run=%0b done=%0b res=%h ovf=%b, want 1 0 0 0 0", idle_o, running_o, done_o, result_o, ovf_o);
    end
    reset = 1'b0; run_i = 1'b0; valid_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_job(3, 2, 1, 1);
    n_tests++;
    if (result_o !== 64'h000C_0009_0006_0003) begin
      n_fail++;
      $display("FAIL basic_123: res=%h, want 000c000900060003", result_o);
    end
  endtask

  task automatic test_len_zero();
    run_job(0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    run_job(258, 1, 0, 1);
    n_tests++;
`ifdef ACC_ARRAY_SAT_EN
    if (ovf_o !== 4'b0001 || result_o[15:0] !== 16'hFFFF) begin
`else
    if (ovf_o !== 4'b0001 || result_o[15:0] !== 16'd254) begin
`endif
      n_fail++;
      $display("FAIL overflow_lane0: ovf=%b lane0=%0d", ovf_o, result_o[15:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    run_i = 1'b1; len_i = 9'd5; valid_i = 1'b0;
    tick();
    run_i = 1'b0; valid_i = 1'b1; number_i = 32'h0403_0201;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; valid_i = 1'b0;
    n_tests++;
    if (idle_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || ovf_o !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: idle=%0b run=%0b done=%0b res=%h, want 1 0 0 0", idle_o, running_o, done_o, result_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (done_o !== 1'b0 || idle_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_no_done: done=%0b idle=%0b, want done=0 idle=1", done_o, idle_o);
      end
    end
    run_job(1, 3, 0, 0);
    n_tests++;
    if (result_o !== 64'h0007_0007_0007_0007) begin
      n_fail++;
      $display("FAIL after_reset_job: res=%h, want 0007000700070007", result_o);
    end
  endtask

  function automatic logic [NCH*DW-1:0] add_pk(input logic [NCH*DW-1:0] a, input logic [NCH*IW-1:0] n);
    logic [NCH*DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = a[k*DW +: DW] + DW'(n[k*IW +: IW]);
    return r;
  endfunction

  task automatic test_run_held();
    logic [NCH*DW-1:0] exp_r;
    valid_i = 1'b1; run_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      number_i = $urandom;
      tick();
    end
    n_tests++;
    if (idle_o !== 1'b1 || result_o !== 64'h0007_0007_0007_0007) begin
      n_fail++;
      $display("FAIL idle_valid: idle=%0b res=%h, want idle=1 res=0007000700070007", idle_o, result_o);
    end
    for (int job = 0; job < 2; job++) begin
      if (job == 0) begin
        run_i = 1'b1; len_i = 9'd2; number_i = $urandom;
        tick();
      end
      n_tests++;
      if (running_o !== 1'b1 || result_o !== '0) begin
        n_fail++;
        $display("FAIL held_start%0d: run=%0b res=%h, want run=1 res=0", job, running_o, result_o);
      end
      if (job == 1) run_i = 1'b0;
      exp_r = '0;
      for (int b = 0; b < 2; b++) begin
        number_i = $urandom;
        exp_r = add_pk(exp_r, number_i);
        tick();
      end
      n_tests++;
      if (done_o !== 1'b1 || result_o !== exp_r) begin
        n_fail++;
        $display("FAIL held_done%0d: done=%0b res=%h, want done=1 res=%h", job, done_o, result_o, exp_r);
      end
      number_i = $urandom;
      tick();
      n_tests++;
      if (idle_o !== 1'b1 || done_o !== 1'b0 || result_o !== exp_r) begin
        n_fail++;
        $display("FAIL held_idle%0d: idle=%0b done=%0b res=%h, want idle=1 done=0 res=%h", job, idle_o, done_o, result_o, exp_r);
      end
      if (job == 0) begin
        number_i = $urandom;
        tick();
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) run_job($urandom_range(0, 20), 0, 0, 2);
    run_job(300, 4, 0, 0);
    run_job(4, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b0; run_i = 1'b0; valid_i = 1'b0; len_i = '0; number_i = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_overflow();
    test_reset_mid_run();
    test_run_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
